// File: rtl/timer_defs.sv
// timer_defs: shared state encodings, register offsets, CTRL bit positions and mode constants for timer_counter
package timer_defs;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_P    = 4;
  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits a one-cycle tick every p+1 cycles while run is high (built only with TIMER_PRESCALE_EN)
// Ports: clk, reset (async, active-high), clear (restart the divider), run (advance), p (divide-by minus one), tick.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  input  logic [3:0] p,
  output logic       tick
);
  logic [3:0] cnt;
  assign tick = run && cnt == p;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 4'd1;
endmodule
`endif

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with one-shot (level irq) and periodic (pulse irq, auto-reload) modes
// Ports: clk, reset (async, active-high), addr/we/wdata (bus write, 0=CTRL 1=PRESET 2=COUNT), rdata (comb read), irq.
// Build option TIMER_PRESCALE_EN adds CTRL[7:4] prescale field P (one count step every P+1 cycles).
module timer_counter
  import timer_defs::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  state_t state, state_d;
  logic en, im, flag, tick;
  logic [1:0] mode;
  logic [3:0] p;
  logic [31:0] preset, count;
  logic wr_ctrl, wr_preset, wr_cfg, periodic, step, done;
  assign wr_ctrl   = we && addr == ADDR_CTRL;
  assign wr_preset = we && addr == ADDR_PRESET;
  assign wr_cfg    = wr_ctrl || wr_preset;
  assign periodic  = mode == MODE_PERIODIC;
  assign step      = state == CNT && en && tick;
  assign done      = count <= 32'd1;
`ifdef TIMER_PRESCALE_EN
  logic [3:0] p_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) p_q <= '0;
    else if (wr_ctrl) p_q <= wdata[CTRL_P+:4];
  assign p = p_q;
  timer_prescaler u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(wr_cfg || state == LOAD),
    .run  (state == CNT && en),
    .p    (p),
    .tick (tick)
  );
`else
  assign p    = 4'd0;
  assign tick = 1'b1;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  // a CTRL/PRESET write overrides whatever the FSM would have done this edge
  always_comb begin
    state_d = state;
    if (wr_cfg) state_d = IDLE;
    else
      case (state)
        IDLE:    state_d = en ? LOAD : IDLE;
        LOAD:    state_d = CNT;
        CNT:     state_d = !en ? IDLE : (tick && done) ? INT : CNT;
        INT:     state_d = periodic ? LOAD : IDLE;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      im     <= 1'b0;
      preset <= PRESET_RST;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en   <= wdata[CTRL_EN];
        mode <= wdata[CTRL_MODE+:2];
        im   <= wdata[CTRL_IM];
      end else if (!wr_preset && state == INT && !periodic) en <= 1'b0;
      if (wr_preset) preset <= wdata;
      if (wr_cfg) flag <= 1'b0;
      else if (step && done) flag <= 1'b1;
      else if (state == INT && periodic) flag <= 1'b0;
      if (!wr_cfg && state == LOAD) count <= preset;
      else if (!wr_cfg && step) count <= done ? '0 : count - 32'd1;
    end
  always_comb begin
    irq   = im & flag;
    rdata = addr == ADDR_CTRL   ? {24'd0, p, im, mode, en} :
            addr == ADDR_PRESET ? preset :
            addr == ADDR_COUNT  ? count : '0;
  end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: randomized scoreboard bench; expectations come from a closed-form timing model of the timer
module tb_timer_counter;
`ifdef TIMER_PRESCALE_EN
  localparam bit PS = 1'b1;
`else
  localparam bit PS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, we = 1'b0, irq;
  logic [1:0] addr = 2'd0;
  logic [31:0] wdata = '0, rdata;
  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] rd;
    logic        irq;
    logic [1:0]  a;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  // model: a run starts at the edge of an enabling write; k counts edges since then
  logic [31:0] preset_m, base;
  logic [1:0] mode_m;
  logic im_m, running;
  int p_m, k;
  task automatic model_reset();
    preset_m = '0; base = '0; mode_m = 2'd0; im_m = 1'b0; running = 1'b0; p_m = 0; k = 0;
  endtask
  function automatic void model_now(output logic [31:0] c, output logic f, output logic e);
    longint per, len, s, j;
    per = longint'(p_m) + 1;
    len = preset_m == 0 ? 1 : longint'(preset_m);
    s = len * per;
    c = base;
    f = 1'b0;
    e = running;
    if (running && k >= 2) begin
      j = longint'(k) - 2;
      if (mode_m == 2'd1) begin
        j = j % (s + 2);
        c = j < s ? preset_m - 32'(j / per) : '0;
        f = j == s;
      end else begin
        c = j < s ? preset_m - 32'(j / per) : '0;
        f = j >= s;
        e = j <= s;
      end
    end
  endfunction
  function automatic exp_t expect_for(logic [1:0] a);
    exp_t x;
    logic [31:0] c;
    logic f, e;
    model_now(c, f, e);
    x.a = a;
    x.irq = im_m & f;
    x.rd = a == 2'd0 ? {24'd0, 4'(p_m), im_m, mode_m, e} : a == 2'd1 ? preset_m : a == 2'd2 ? c : '0;
    return x;
  endfunction
  task automatic advance(input logic w, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] c;
    logic f, e;
    model_now(c, f, e);
    if (w && (a == 2'd0 || a == 2'd1)) begin
      if (a == 2'd0) begin
        im_m = d[3];
        mode_m = d[2:1];
        p_m = PS ? int'(d[7:4]) : 0;
        running = d[0];
      end else begin
        preset_m = d;
        running = e;
      end
      base = c;
      k = 0;
    end else k++;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      check($sformatf("rdata[%0d]", x.a), rdata, x.rd);
      check("irq", {31'd0, irq}, {31'd0, x.irq});
    end
  end
  task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d);
    we = w;
    addr = a;
    wdata = d;
    q.push_back(expect_for(a));
    @(posedge clk);
    #1;
    advance(w, a, d);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, a, d);
  endtask
  function automatic logic [31:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    return {($urandom_range(0, 1) != 0) ? r[31:8] : 24'd0, 2'b00, r[5:4], 4'($urandom_range(0, 15))};
  endfunction
  task automatic idle(input int n, input int wr_pct);
    for (int i = 0; i < n; i++)
      if (int'($urandom_range(0, 99)) < wr_pct) cycle(1'b1, 2'($urandom_range(0, 3)), rnd_data());
      else cycle(1'b0, 2'($urandom_range(0, 3)), $urandom);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] r, ctl;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) cycle(1'b0, 2'(a), '0);
    wr(2'd1, 32'd5); wr(2'd0, 32'h9); idle(12, 0); wr(2'd1, 32'd5); idle(3, 0);
    wr(2'd1, 32'd3); wr(2'd0, 32'hB); idle(24, 0);
    wr(2'd1, 32'd0); wr(2'd0, 32'h9); idle(5, 0); wr(2'd0, 32'h1); idle(6, 0);
    wr(2'd1, 32'd10); wr(2'd0, 32'h9); idle(5, 0); wr(2'd0, 32'h8); idle(5, 0);
    wr(2'd2, 32'd77); wr(2'd3, 32'hFFFF_FFFF); idle(2, 0);
    wr(2'd1, 32'd2); wr(2'd0, 32'h39); idle(14, 0);
    for (int s = 0; s < 40; s++) begin
      r = $urandom;
      ctl = {r[31:8], 2'b00, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 5) != 0)};
      wr(2'd1, 32'($urandom_range(0, 6)));
      wr(2'd0, ctl);
      idle(int'($urandom_range(4, 30)), 8);
    end
    wr(2'd1, 32'd100); wr(2'd0, 32'h9); idle(8, 0);
    check("queue drained", 32'(q.size()), 32'd0);
    #2 reset = 1'b1;
    addr = 2'd2;
    we = 1'b0;
    #1 check("async count", rdata, 32'd0);
    check("async irq", {31'd0, irq}, 32'd0);
    addr = 2'd0;
    #1 check("async ctrl", rdata, 32'd0);
    addr = 2'd1;
    #1 check("async preset", rdata, 32'd0);
    @(negedge clk) reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    idle(6, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable timer on the system bridge, downstream of the CPU data port. It consumes the CPU's M-stage data-bus writes and reads, and produces one interrupt line into `hw_int`. It counts down from a software-loaded preset. In mode 0 it raises a level interrupt and stops. In mode 1 it emits a one-cycle pulse and auto-reloads.

## Interface
Parameters:
- `PRESET_RST`, 32'h0, reset value of PRESET.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `addr`  in  2  word offset from the bridge: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- `we`  in  1  write strobe. The bridge asserts it for a selected, full-word store (`byteen` = 4'hf).
- `wdata`  in  32  store data.
- `rdata`  out  32  combinational read of the addressed register.
- `irq`  out  1  interrupt to the CPU `hw_int` bit 2.

## Operation
- Registers:
  - CTRL[0] EN, CTRL[2:1] MODE, CTRL[3] IM (interrupt mask, 1 = enabled). Other CTRL bits read 0.
  - PRESET is 32-bit read/write.
  - COUNT is 32-bit read-only; writes are ignored.
  - Unmapped offset reads 0.
- State machine states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT ← PRESET → CNT.
  - CNT: EN=0 → IDLE (COUNT holds). If COUNT > 1, COUNT ← COUNT−1. If COUNT ≤ 1, COUNT ← 0, set irq_flag, → INT.
  - INT, MODE 0: EN ← 0, → IDLE. irq_flag stays set.
  - INT, MODE 1: irq_flag ← 0, → LOAD (auto-reload).
- MODE 2 and 3 behave as MODE 0.
- `irq` = IM & irq_flag.
- A write to CTRL or PRESET:
  - forces state ← IDLE and clears irq_flag on the same edge;
  - the register write takes priority over any same-cycle FSM update of CTRL.EN.
- Arithmetic: unsigned 32-bit. COUNT never wraps below 0.
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, state IDLE, irq_flag=0. Therefore `irq`=0 and `rdata`=0 for offsets 0, 2 and 3.
- Reset asserted mid-count aborts immediately; no interrupt is generated.

## Timing
- Register write at edge t is visible on `rdata` after edge t.
- EN written at edge t, PRESET = N:
  - t+1: state LOAD.
  - t+2: COUNT = N, state CNT.
  - `irq` rises after edge t+2+max(N,1).
- MODE 0: `irq` stays high until software writes CTRL or PRESET, or until reset.
- MODE 1:
  - `irq` is high for exactly 1 cycle per period.
  - Period is max(N,1)+2 cycles (INT and LOAD each cost one).
- Clearing EN in CNT freezes COUNT on the next edge.
- Re-setting EN restarts from LOAD with a fresh PRESET.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - CTRL[7:4] is a prescale field P (read/write, reset 0).
  - In CNT, one decrement or terminal action occurs every P+1 cycles.
  - The prescale counter clears on LOAD and on any CTRL/PRESET write.
  - The MODE 1 period becomes max(N,1)·(P+1)+2 cycles.
- Undefined: CTRL[7:4] reads 0, writes are ignored, and the block decrements every cycle.

## Structure
- Shared package/header `timer_defs`:
  - state encodings IDLE/LOAD/CNT/INT;
  - register offsets CTRL=0, PRESET=1, COUNT=2;
  - CTRL bit positions;
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1.
- Sub-module `timer_prescaler` (present only under `TIMER_PRESCALE_EN`):
  - inputs: clear, run, P;
  - output: one-cycle tick;
  - without the macro, tick is tied to 1.

## Test plan
- Reset then read all offsets → 0; PRESET reads PRESET_RST; `irq`=0.
- PRESET=5, CTRL=4'b1001 (IM, mode 0, EN) → `irq` rises 7 cycles after the CTRL write. COUNT reads 0, CTRL.EN reads 0, `irq` stays high. A PRESET write drops `irq` the next cycle.
- PRESET=3, CTRL=4'b1011 (mode 1) → `irq` is a 1-cycle pulse every 5 cycles for ≥4 periods; COUNT sequence 3,2,1,0.
- PRESET=0 with EN → `irq` after 3 cycles; IM=0 → irq_flag sets, `irq` stays 0.
- Clear EN mid-count (COUNT=10, write CTRL EN=0) → COUNT frozen at its value ≤10, no `irq`. Assert `reset` mid-count → all registers cleared asynchronously, before the next edge.
- With `TIMER_PRESCALE_EN`, P=3, PRESET=2, mode 0 → `irq` after 2 + 2·4 = 10 cycles; COUNT changes only every 4th cycle.
